// File: rtl/gate_pipe.sv
// gate_pipe -- elastic pipeline computing a selectable 2-input logic gate.
//
// Each accepted operand set (op, a, b) is evaluated into a bitwise result y
// and a single reduction bit red, then carried through STAGES registered
// stages with valid/ready flow control. A stage advances only when the next
// stage is empty or advancing itself, so a full pipe still accepts a new set
// in the same cycle the oldest one leaves.
//
// Parameters:
//   WIDTH   operand/result width in bits (1..32)
//   STAGES  pipeline depth in clock cycles (1..8)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset; empties the pipe
//   in_valid   operand set present
//   in_ready   pipe accepts the operand set this cycle
//   op         gate select: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 BUF, 7 NOT
//   a, b       operands (b ignored for BUF and NOT)
//   out_valid  result present in the last stage
//   out_ready  consumer takes the result this cycle
//   y          bitwise result
//   red        reduction over all 2*WIDTH bits of {a,b} (a[0]-based for BUF/NOT)
//   done_cnt   (only with GATE_PIPE_CNT_EN) saturating count of delivered results
//
// Build option: define GATE_PIPE_CNT_EN to add the done_cnt output and counter.

module gate_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             red
`ifdef GATE_PIPE_CNT_EN
    ,
    output logic [15:0]      done_cnt
`endif
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_BUF  = 3'd6,
        OP_NOT  = 3'd7
    } gate_op_e;

    gate_op_e          op_sel;
    logic [WIDTH-1:0]  y_next;
    logic              red_next;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] red_q;
    logic [WIDTH-1:0]  y_q [STAGES];
    logic [STAGES-1:0] adv;

    assign op_sel = gate_op_e'(op);

    // Gate evaluation happens before stage 0, so stage 0 already holds results.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case can leave it unassigned and infer a latch.
        y_next   = '0;
        red_next = 1'b0;
        case (op_sel)
            OP_AND:  begin y_next = a & b;    red_next = &{a, b};  end
            OP_NAND: begin y_next = ~(a & b); red_next = ~&{a, b}; end
            OP_OR:   begin y_next = a | b;    red_next = |{a, b};  end
            OP_NOR:  begin y_next = ~(a | b); red_next = ~|{a, b}; end
            OP_XOR:  begin y_next = a ^ b;    red_next = ^{a, b};  end
            OP_XNOR: begin y_next = ~(a ^ b); red_next = ~^{a, b}; end
            OP_BUF:  begin y_next = a;        red_next = a[0];     end
            OP_NOT:  begin y_next = ~a;       red_next = ~a[0];    end
            default: ;
        endcase
    end

    // Advance chain resolved from the output side backwards: a stage moves
    // when it holds data and its successor is empty or moving too. This keeps
    // in_ready combinational from out_ready so a full pipe has no bubble.
    always_comb begin
        adv             = '0;
        adv[STAGES-1]   = valid_q[STAGES-1] && out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = valid_q[i] && (!valid_q[i+1] || adv[i+1]);
        end
    end

    assign in_ready = !valid_q[0] || adv[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset as well as the valid bits,
            // because y and red must read zero while reset is held.
            valid_q <= '0;
            red_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // stage samples its predecessor's pre-edge value.
            if (in_ready) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    y_q[0]   <= y_next;
                    red_q[0] <= red_next;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (!valid_q[i] || adv[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        y_q[i]   <= y_q[i-1];
                        red_q[i] <= red_q[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign y         = y_q[STAGES-1];
    assign red       = red_q[STAGES-1];

`ifdef GATE_PIPE_CNT_EN
    logic [15:0] cnt_q;

    // Saturating count of completed output transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign done_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gate_pipe.sv
// Testbench for gate_pipe (WIDTH=4, STAGES=2): directed scenarios plus a
// randomized run scored against a queue-based reference model.
module tb_gate_pipe;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         red;
`ifdef GATE_PIPE_CNT_EN
    logic [15:0]  done_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Expected results in acceptance order, packed as {red, y}.
    logic [W:0] sb [$];

    gate_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .red       (red)
`ifdef GATE_PIPE_CNT_EN
        ,
        .done_cnt  (done_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: per-bit truth tables indexed by {a_i, b_i}; reduction
    // from the count of ones among all 2*W operand bits.
    function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] aa,
                                         input logic [W-1:0] bb);
        logic [3:0]   tt;
        logic [W-1:0] yy;
        logic         rr;
        int           n;
        n  = $countones({aa, bb});
        tt = 4'b0000;
        case (o)
            3'd0: begin tt = 4'b1000; rr = (n == 2 * W); end
            3'd1: begin tt = 4'b0111; rr = (n != 2 * W); end
            3'd2: begin tt = 4'b1110; rr = (n != 0);     end
            3'd3: begin tt = 4'b0001; rr = (n == 0);     end
            3'd4: begin tt = 4'b0110; rr = (n % 2 == 1); end
            3'd5: begin tt = 4'b1001; rr = (n % 2 == 0); end
            3'd6: rr = aa[0];
            default: rr = !aa[0];
        endcase
        for (int i = 0; i < W; i++) begin
            if (o == 3'd6)      yy[i] = aa[i];
            else if (o == 3'd7) yy[i] = !aa[i];
            else                yy[i] = tt[{aa[i], bb[i]}];
        end
        return {rr, yy};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] aa,
                         input logic [W-1:0] bb);
        in_valid = v;
        op       = o;
        a        = aa;
        b        = bb;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 3'd0, '0, '0);
        tick();
        #1;
        checks++;
        if ({out_valid, in_ready, red, y} !== {1'b0, 1'b1, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got ov=%b ir=%b red=%b y=%b want ov=0 ir=1 red=0 y=0000",
                     out_valid, in_ready, red, y);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(1'b1, 3'd0, 4'b1010, 4'b0110);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_in_ready: got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 3'd0, '0, '0);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: out_valid got %b want 0 one edge after accept", out_valid);
        end
        tick();
        #1;
        checks++;
        if ({out_valid, red, y} !== {1'b1, 1'b0, 4'b0010}) begin
            errors++;
            $display("FAIL basic_result: got ov=%b red=%b y=%b want ov=1 red=0 y=0010",
                     out_valid, red, y);
        end
        tick();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops [3];
        logic [W:0]   exp [3];
        ops[0] = 3'd2; ops[1] = 3'd4; ops[2] = 3'd7;
        exp[0] = {1'b1, 4'b1011};
        exp[1] = {1'b1, 4'b1011};
        exp[2] = {1'b0, 4'b0100};
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) drive(1'b1, ops[c], 4'b1011, 4'b0000);
            else       drive(1'b0, 3'd0, '0, '0);
            #1;
            if (c < 3) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, in_ready);
                end
            end
            if (c >= 2 && c < 5) begin
                checks++;
                if ({out_valid, red, y} !== {1'b1, exp[c-2]}) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got ov=%b red=%b y=%b want ov=1 red=%b y=%b",
                             c - 2, out_valid, red, y, exp[c-2][W], exp[c-2][W-1:0]);
                end
            end
            if (c == 5) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_drain: out_valid got %b want 0", out_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [2:0]   so [3];
        logic [W-1:0] sa [3];
        logic [W-1:0] sbv [3];
        logic [W:0]   e  [3];
        for (int i = 0; i < 3; i++) begin
            so[i]  = 3'($urandom_range(0, 7));
            sa[i]  = W'($urandom);
            sbv[i] = W'($urandom);
            e[i]   = model(so[i], sa[i], sbv[i]);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, so[i], sa[i], sbv[i]);
            #1;
            checks++;
            if (in_ready !== (i < 2)) begin
                errors++;
                $display("FAIL stall_in_ready[%0d]: got %b want %b", i, in_ready, (i < 2));
            end
            tick();
        end
        // Pipe full, consumer stalled: output must hold.
        #1;
        checks++;
        if ({out_valid, in_ready, red, y} !== {1'b1, 1'b0, e[0]}) begin
            errors++;
            $display("FAIL stall_hold: got ov=%b ir=%b {red,y}=%b want ov=1 ir=0 {red,y}=%b",
                     out_valid, in_ready, {red, y}, e[0]);
        end
        // Release: full pipe accepts the third set while the oldest leaves.
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_full_pass: in_ready got %b want 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({out_valid, red, y} !== {1'b1, e[i]}) begin
                errors++;
                $display("FAIL stall_order[%0d]: got ov=%b {red,y}=%b want ov=1 {red,y}=%b",
                         i, out_valid, {red, y}, e[i]);
            end
            tick();
            drive(1'b0, 3'd0, '0, '0);
        end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_in_flight();
        logic [W:0] e;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            tick();
        end
        drive(1'b0, 3'd0, '0, '0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, red, y} !== {1'b1 ^ 1'b1, 1'b1, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL rst_flight_async: got ov=%b ir=%b red=%b y=%b want ov=0 ir=1 red=0 y=0000",
                     out_valid, in_ready, red, y);
        end
        tick();
        // Release and offer a new set immediately; it must be taken at once.
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 3'd5, 4'b1100, 4'b1010);
        e = model(3'd5, 4'b1100, 4'b1010);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_accept: in_ready got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 3'd0, '0, '0);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_stale: out_valid got %b want 0", out_valid);
        end
        tick();
        #1;
        checks++;
        if ({out_valid, red, y} !== {1'b1, e}) begin
            errors++;
            $display("FAIL rst_new_result: got ov=%b {red,y}=%b want ov=1 {red,y}=%b",
                     out_valid, {red, y}, e);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_after[%0d]: out_valid got %b want 0", i, out_valid);
            end
        end
    endtask

    // One randomized cycle, sampled at negedge+1 and scored against sb.
    task automatic rand_cycle();
        #1;
        if (out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rand_spurious: out_valid=1 with {red,y}=%b but no set pending", {red, y});
            end else if ({red, y} !== sb[0]) begin
                errors++;
                $display("FAIL rand_data: got {red,y}=%b want %b", {red, y}, sb[0]);
            end
        end
        if (sb.size() == 0) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_empty_ready: in_ready got %b want 1", in_ready);
            end
        end
        if (out_valid && out_ready) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_pass_ready: in_ready got %b want 1", in_ready);
            end
        end
        if (!out_ready && sb.size() == S) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL rand_full_ready: in_ready got %b want 0", in_ready);
            end
        end
        if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
        if (in_valid && in_ready) sb.push_back(model(op, a, b));
        tick();
    endtask

    task automatic test_random();
        sb.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            a         = W'($urandom);
            b         = W'($urandom);
            rand_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            rand_cycle();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: %0d sets still pending want 0", sb.size());
        end
    endtask

`ifdef GATE_PIPE_CNT_EN
    task automatic send_n(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            tick();
        end
        drive(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < S + 2; i++) tick();
    endtask

    task automatic test_counter();
        rst_n = 1'b0;
        tick();
        #1;
        checks++;
        if (done_cnt !== 16'd0) begin
            errors++;
            $display("FAIL cnt_reset: got %h want 0000", done_cnt);
        end
        rst_n = 1'b1;
        tick();
        send_n(5);
        checks++;
        if (done_cnt !== 16'd5) begin
            errors++;
            $display("FAIL cnt_five: got %0d want 5", done_cnt);
        end
        force dut.cnt_q = 16'hFFFE;
        tick();
        release dut.cnt_q;
        tick();
        send_n(2);
        checks++;
        if (done_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_reach_max: got %h want ffff", done_cnt);
        end
        send_n(1);
        checks++;
        if (done_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_saturate: got %h want ffff", done_cnt);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_reset_in_flight();
        test_random();
`ifdef GATE_PIPE_CNT_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
